// File: rtl/matrix_pkg.sv
// Shared types and index helpers for the matrix multiply-accumulate responder.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_GEN,
    WAIT_ACUM
  } state_t;

  localparam int DIM_DEFAULT = 3;

  function automatic int addr_width(input int dim);
    return (dim * dim <= 2) ? 1 : $clog2(dim * dim);
  endfunction

  function automatic int acc_width(input int dim, input int data_w);
    return 2 * data_w + $clog2(dim);
  endfunction

  function automatic int idx(input int r, input int c, input int dim);
    return r * dim + c;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply, extend and add for one dot-product term.
// MATRIX_MAC_SIGNED_EN selects two's-complement operands; otherwise unsigned.
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  sum
);

  localparam int PROD_W = 2 * DATA_W;

  logic [ACC_W-1:0] prod_ext;

`ifdef MATRIX_MAC_SIGNED_EN
  logic signed [PROD_W-1:0] prod;
  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
`else
  logic [PROD_W-1:0] prod;
  assign prod     = a * b;
  assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod};
`endif

  assign sum = acc + prod_ext;

endmodule

// File: rtl/matrix_mac_responder.sv
// Responder side of the gen-address / accumulate protocol: walks every C[i][j] of C = A*B.
// Build with MATRIX_MAC_SIGNED_EN for signed operands (unsigned by default).
module matrix_mac_responder
  import matrix_pkg::*;
#(
  parameter int DIM    = DIM_DEFAULT,
  parameter int DATA_W = 8,
  parameter int ADDR_W = addr_width(DIM),
  parameter int ACC_W  = acc_width(DIM, DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              req,
  input  logic              gen_addr,
  input  logic              acum,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic [ACC_W-1:0]  result,
  output logic [ADDR_W-1:0] result_addr,
  output logic              result_valid,
  output logic              done,
  output logic              busy,
  output logic              proto_err
);

  localparam int IDX_W = $clog2(DIM);

  state_t           state, state_next;
  logic [IDX_W-1:0] i, j, k;
  logic [ACC_W-1:0] acc, acc_next;
  logic             last_term, last_col, last_elem;

  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .a   (a_data),
    .b   (b_data),
    .acc (acc),
    .sum (acc_next)
  );

  assign last_term = (k == IDX_W'(DIM - 1));
  assign last_col  = (j == IDX_W'(DIM - 1));
  assign last_elem = last_col && (i == IDX_W'(DIM - 1));
  assign req       = (state == REQ);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (go) state_next = REQ;
      REQ:       state_next = WAIT_GEN;
      WAIT_GEN:  if (gen_addr && !acum) state_next = WAIT_ACUM;
      WAIT_ACUM: if (acum) state_next = (last_term && last_elem) ? IDLE : REQ;
    endcase
  end

  // Simultaneous gen_addr and acum: acum is judged by the current state and gen_addr is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      i            <= '0;
      j            <= '0;
      k            <= '0;
      acc          <= '0;
      addr_a       <= '0;
      addr_b       <= '0;
      result       <= '0;
      result_addr  <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state        <= state_next;
      result_valid <= 1'b0;
      done         <= 1'b0;
      if (done) busy <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            busy      <= 1'b1;
            proto_err <= 1'b0;
          end
        end
        REQ: begin
          if (acum) proto_err <= 1'b1;
        end
        WAIT_GEN: begin
          if (acum) begin
            proto_err <= 1'b1;
          end else if (gen_addr) begin
            addr_a <= ADDR_W'(idx(int'(i), int'(k), DIM));
            addr_b <= ADDR_W'(idx(int'(k), int'(j), DIM));
          end
        end
        WAIT_ACUM: begin
          if (gen_addr) proto_err <= 1'b1;
          if (acum) begin
            if (!last_term) begin
              acc <= acc_next;
              k   <= k + 1'b1;
            end else begin
              result       <= acc_next;
              result_addr  <= ADDR_W'(idx(int'(i), int'(j), DIM));
              result_valid <= 1'b1;
              done         <= last_elem;
              acc          <= '0;
              k            <= '0;
              if (last_col) begin
                j <= '0;
                i <= last_elem ? '0 : i + 1'b1;
              end else begin
                j <= j + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mac_responder.sv
// Self-checking bench for matrix_mac_responder with a controller model and a C = A*B scoreboard.
module tb_matrix_mac_responder;

  localparam int DIM    = 3;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int ACC_W  = 18;
  localparam int N      = DIM * DIM;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              go = 1'b0;
  logic              tb_gen = 1'b0, tb_acum = 1'b0;
  logic              ctrl_gen = 1'b0, ctrl_acum = 1'b0;
  logic              gen_addr, acum, req;
  logic [ADDR_W-1:0] addr_a, addr_b, result_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic [ACC_W-1:0]  result;
  logic              result_valid, done, busy, proto_err;

  logic [DATA_W-1:0] mem_a [N];
  logic [DATA_W-1:0] mem_b [N];

  int n_cmp = 0;
  int n_fail = 0;
  int req_count = 0;

  assign gen_addr = ctrl_gen | tb_gen;
  assign acum     = ctrl_acum | tb_acum;
  assign a_data   = (int'(addr_a) < N) ? mem_a[addr_a] : '0;
  assign b_data   = (int'(addr_b) < N) ? mem_b[addr_b] : '0;

  always #5 clk = ~clk;

  matrix_mac_responder #(.DIM(DIM), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .req          (req),
    .gen_addr     (gen_addr),
    .acum         (acum),
    .addr_a       (addr_a),
    .addr_b       (addr_b),
    .a_data       (a_data),
    .b_data       (b_data),
    .result       (result),
    .result_addr  (result_addr),
    .result_valid (result_valid),
    .done         (done),
    .busy         (busy),
    .proto_err    (proto_err)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference C element straight from the matrix definition, reduced to ACC_W bits.
  function automatic logic [ACC_W-1:0] model_c(input int r, input int c);
    longint s = 0;
    logic [63:0] s_bits;
    for (int kk = 0; kk < DIM; kk++) begin
`ifdef MATRIX_MAC_SIGNED_EN
      s += longint'($signed(mem_a[r*DIM+kk])) * longint'($signed(mem_b[kk*DIM+c]));
`else
      s += longint'(mem_a[r*DIM+kk]) * longint'(mem_b[kk*DIM+c]);
`endif
    end
    s_bits = s;
    return s_bits[ACC_W-1:0];
  endfunction

  task automatic load_mats(input int mode);
    for (int n = 0; n < N; n++) begin
      case (mode)
        0: begin mem_a[n] = (n / DIM == n % DIM) ? 8'd1 : 8'd0; mem_b[n] = DATA_W'(n + 1); end
        1: begin mem_a[n] = 8'hFF; mem_b[n] = 8'hFF; end
        2: begin mem_a[n] = 8'hFF; mem_b[n] = 8'd2; end
        default: begin mem_a[n] = DATA_W'(n + 1); mem_b[n] = DATA_W'(N - n); end
      endcase
    end
  endtask

  task automatic apply_stimulus();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
    end
    check_output("done_reached", done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_req"}, req, 0);
    check_output({tag, "_addr_a"}, addr_a, 0);
    check_output({tag, "_addr_b"}, addr_b, 0);
    check_output({tag, "_result"}, result, 0);
    check_output({tag, "_result_addr"}, result_addr, 0);
    check_output({tag, "_result_valid"}, result_valid, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_proto_err"}, proto_err, 0);
  endtask

  // Operate-signals controller: 4-cycle wait to gen_addr, acum three cycles later.
  initial begin
    forever begin
      @(posedge clk); #1;
      while (req) begin
        for (int c = 1; c <= 8; c++) begin
          @(posedge clk); #1;
          ctrl_gen  = (c == 4);
          ctrl_acum = (c == 7);
        end
      end
    end
  end

  // Scoreboard: protocol phase, term addresses, result order, busy/proto_err/done timing.
  initial begin
    bit mbusy = 0, mperr = 0, gen_seen = 0, nb, np, old_gen;
    int e = 0, t = 0, el, kk;
    logic [ACC_W-1:0] last_res = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mbusy = 0; mperr = 0; gen_seen = 0; e = 0; t = 0; last_res = '0;
        continue;
      end
      if (req) req_count++;
      check_output("busy", busy, mbusy);
      check_output("proto_err", proto_err, mperr);
      nb = mbusy;
      np = mperr;
      old_gen = gen_seen;
      if (mbusy) begin
        if (acum) begin
          if (old_gen) begin
            el = t / DIM;
            kk = t % DIM;
            check_output("addr_a", addr_a, (el / DIM) * DIM + kk);
            check_output("addr_b", addr_b, kk * DIM + (el % DIM));
            t++;
            gen_seen = 0;
          end else begin
            np = 1;
          end
        end
        if (gen_addr) begin
          if (old_gen) np = 1;
          else if (!acum) gen_seen = 1;
        end
      end
      if (result_valid) begin
        if (!mbusy || e >= N) begin
          check_output("unexpected_result_valid", result_valid, 0);
        end else begin
          check_output("result", result, model_c(e / DIM, e % DIM));
          check_output("result_addr", result_addr, e);
          e++;
          check_output("done_with_last", done, e == N);
          if (e == N) nb = 0;
        end
        last_res = result;
      end else begin
        check_output("done_alone", done, 0);
        check_output("result_hold", result, last_res);
      end
      if (go && !mbusy) begin
        nb = 1; np = 0; e = 0; t = 0; gen_seen = 0;
      end
      mbusy = nb;
      mperr = np;
    end
  end

  initial begin
    int cyc;
    int req_before;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity times 1..9: C equals B, in 9*3*8 cycles from the first req.
    load_mats(0);
    check_output("model_c11_identity", model_c(1, 1), 5);
    apply_stimulus();
    check_output("first_req", req, 1);
    wait_done(cyc);
    check_output("product_cycles", cyc, 9 * 3 * 8);
    check_output("last_result", result, 9);
    check_output("last_result_addr", result_addr, 8);
    @(posedge clk); #1;
    check_output("busy_after_done", busy, 0);

`ifdef MATRIX_MAC_SIGNED_EN
    load_mats(2);
    check_output("model_c01_signed", model_c(0, 1), 18'h3FFFA);
    apply_stimulus();
    wait_done(cyc);
    check_output("signed_result", result, 18'h3FFFA);
`else
    load_mats(1);
    check_output("model_c22_max", model_c(2, 2), 195075);
    apply_stimulus();
    wait_done(cyc);
    check_output("max_result", result, 195075);
`endif
    @(posedge clk); #1;

    // Out-of-place acum while waiting for gen_addr on term 0.
    load_mats(3);
    apply_stimulus();
    @(posedge clk); #1;
    tb_acum = 1'b1;
    @(posedge clk); #1;
    tb_acum = 1'b0;
    check_output("proto_err_set", proto_err, 1);
    wait_done(cyc);
    check_output("proto_err_sticky", proto_err, 1);
    @(posedge clk); #1;
    apply_stimulus();
    check_output("proto_err_cleared", proto_err, 0);
    wait_done(cyc);
    @(posedge clk); #1;

    // Asynchronous reset during the 4th element, then a clean restart.
    load_mats(0);
    apply_stimulus();
    repeat (80) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    load_mats(3);
    apply_stimulus();
    wait_done(cyc);
    check_output("restart_cycles", cyc, 9 * 3 * 8);
    @(posedge clk); #1;

    // gen_addr in IDLE and go while busy are both silently ignored.
    tb_gen = 1'b1;
    @(posedge clk); #1;
    tb_gen = 1'b0;
    check_output("idle_gen_req", req, 0);
    check_output("idle_gen_busy", busy, 0);
    check_output("idle_gen_proto_err", proto_err, 0);
    req_before = req_count;
    apply_stimulus();
    repeat (20) @(posedge clk);
    #1 go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    wait_done(cyc);
    check_output("busy_go_cycles", cyc, 9 * 3 * 8 - 21);
    check_output("req_count", req_count - req_before, N * DIM);
    check_output("busy_go_proto_err", proto_err, 0);
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_mac_responder.md
Name: matrix_mac_responder

Overview:
- Responder end of the gen-address / accumulate pulse protocol used by the matrix-multiply datapath.
- Requests each dot-product term from the operate-signals controller with a one-cycle `req` pulse, which drives the controller's `signal` input.
- On the controller's `gen_addr` pulse, it drives A/B memory addresses.
- On the controller's `acum` pulse, it multiply-accumulates the returned operands.
- Walks all DIM×DIM output elements of C = A·B and emits one result per element.

Parameters:
- DIM, 3, matrix dimension; range 2..32.
- DATA_W, 8, operand width.
- ADDR_W, $clog2(DIM*DIM), memory address width.
- ACC_W, 2*DATA_W+$clog2(DIM), accumulator/result width.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  one-cycle start of a full matrix product; ignored unless IDLE.
- req  out  1  one-cycle pulse requesting the next term; connects to the controller's `signal`.
- gen_addr  in  1  controller pulse (its signalGenAddr).
- acum  in  1  controller pulse (its signalAcum).
- addr_a  out  ADDR_W  A read address = i*DIM+k, row-major.
- addr_b  out  ADDR_W  B read address = k*DIM+j, row-major.
- a_data  in  DATA_W  A read data; valid by the acum pulse.
- b_data  in  DATA_W  B read data; valid by the acum pulse.
- result  out  ACC_W  finished C[i][j].
- result_addr  out  ADDR_W  i*DIM+j of `result`.
- result_valid  out  1  one-cycle pulse with result/result_addr.
- done  out  1  one-cycle pulse after the last element.
- busy  out  1  high from go acceptance until the done cycle, inclusive.
- proto_err  out  1  sticky protocol-error flag; cleared by rst or an accepted go.

Behaviour:
- Reset (async, active-high):
  - State IDLE; i=j=k=0; acc=0.
  - Every output is 0: req, addr_a, addr_b, result, result_addr, result_valid, done, busy, proto_err.
  - Reset asserted mid-product aborts it immediately. No result or done is emitted for the aborted product.
- States:
  - IDLE: go=1 → REQ; busy=1; indices, acc and proto_err cleared.
  - REQ: req=1 for exactly this cycle → WAIT_GEN.
  - WAIT_GEN: on gen_addr → WAIT_ACUM; addr_a and addr_b are registered this edge, visible the next cycle, and held stable until the next term.
  - WAIT_ACUM: on acum → acc_next = acc + a_data*b_data, computed at full ACC_W width so there is no overflow for in-range DIM.
    - If k<DIM-1: acc=acc_next; k=k+1 → REQ.
    - If k==DIM-1: result=acc_next; result_addr=i*DIM+j; result_valid=1 for one cycle; acc=0; k=0; advance j, wrapping to 0 and incrementing i on wrap.
    - If that element was the last (i==j==DIM-1): done=1 the same cycle as result_valid → IDLE, with busy cleared the following cycle.
    - Otherwise → REQ.
- Term period: with the controller's fixed 4-cycle wait, one term takes 8 cycles from req to the next req.
- Protocol rules:
  - acum in REQ or WAIT_GEN: ignored; proto_err=1.
  - gen_addr in WAIT_ACUM: ignored; proto_err=1.
  - gen_addr and acum in the same cycle: acum handled per the current state; gen_addr ignored; proto_err=1 if either pulse is out of place.
  - go while busy: ignored, no error.
  - gen_addr/acum in IDLE: ignored, no error.
- result holds its value between result_valid pulses.

Optional Feature:
- Macro MATRIX_MAC_SIGNED_EN.
- Defined: operands are two's-complement; the product is sign-extended to ACC_W before accumulation.
- Undefined: operands are unsigned; the product is zero-extended.

Decomposition:
- Shared package matrix_pkg holds:
  - the state enum (IDLE, REQ, WAIT_GEN, WAIT_ACUM);
  - the DIM default and ADDR_W/ACC_W width functions;
  - the row-major index function idx(r,c)=r*DIM+c.
- One natural sub-module, mac_unit: combinational multiply, extend, and add, with the signedness selected by the macro. The FSM, counters and address registers stay in the top.

Test Plan:
- DIM=3, A=identity, B=1..9 row-major, go pulse, paired with the controller model → 9 result_valid pulses with result=1..9 at result_addr=0..8; done coincides with the 9th; total 9*3*8 cycles.
- DIM=3, A=B=all 0xFF unsigned → every result=3*65025=195075 (fits ACC_W=18); no truncation.
- MATRIX_MAC_SIGNED_EN, A=all -1 (0xFF), B=all 2 → every result=-6 in ACC_W two's-complement.
- acum injected in WAIT_GEN on term 0 → ignored; proto_err=1 and sticky; product completes correctly; next go clears proto_err.
- rst asserted during the 4th element → all outputs 0 asynchronously; a new go restarts at result_addr=0 with acc=0 and no residue.
- go pulsed while busy, and gen_addr pulsed in IDLE → no state change, no proto_err, no extra req.
